// File: rtl/lfsr_range_rng.sv
// Galois LFSR random source with a bounded req/valid draw in [0, limit] by rejection sampling.
// Optional zero-state repair is enabled by defining LFSR_LOCKUP_GUARD_EN.
module lfsr_range_rng #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'h000F,
    parameter int unsigned      MAX_DRAWS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic [WIDTH-1:0] rand_out,
    output logic             rand_valid,
    output logic [WIDTH-1:0] raw_out,
    output logic             lockup
);

    localparam int unsigned CntW = (MAX_DRAWS > 1) ? $clog2(MAX_DRAWS) : 1;
    localparam logic [CntW-1:0] LastDraw = CntW'(MAX_DRAWS - 1);

    typedef enum logic [0:0] {StIdle, StDraw} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] rand_q, rand_d;
    logic             valid_q, valid_d;
    logic             lockup_d;

    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cand;
    logic             stepping;

    assign step_val = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    assign stepping = (state_q == StDraw) || en;

    // Smear limit_q rightwards so mask is the smallest all-ones value covering it.
    always_comb begin
        mask = limit_q;
        for (int i = 1; i < int'(WIDTH); i++) begin
            mask = mask | (limit_q >> i);
        end
    end

    assign cand = lfsr_q & mask;

    always_comb begin
        lfsr_d   = lfsr_q;
        lockup_d = 1'b0;
        if (seed_load) begin
            lfsr_d = seed_in;
        end else if (stepping) begin
            lfsr_d = step_val;
        end
`ifdef LFSR_LOCKUP_GUARD_EN
        if (lfsr_d == '0) begin
            lfsr_d   = SEED;
            lockup_d = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rand_d  = rand_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    limit_d = limit;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                // A seed load pre-empts this cycle's draw entirely.
                if (!seed_load) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cand <= limit_q) begin
                        rand_d  = cand;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else if (cnt_q == LastDraw) begin
                        // cand < 2*(limit_q+1), so one subtraction lands in range.
                        rand_d  = cand - (limit_q + WIDTH'(1));
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            limit_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rand_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            limit_q <= limit_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
        end
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    logic lockup_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end
    assign lockup = lockup_q;
`else
    logic unused_lockup;
    assign unused_lockup = lockup_d;
    assign lockup        = 1'b0;
`endif

    assign busy       = busy_q;
    assign rand_out   = rand_q;
    assign rand_valid = valid_q;
    assign raw_out    = lfsr_q;

endmodule

// File: doc/lfsr_range_rng.md
# lfsr_range_rng

Parametrised Galois LFSR random source that generalises the fixed 8-bit RNG. It adds configurable width and taps, runtime seed loading, and a req/valid handshake that returns a uniformly distributed value in [0, limit] by rejection sampling, with a bounded-latency fallback. Game logic (damage rolls, drops, turn order) uses it directly, and the raw LFSR state remains available for free-running use.

## Interface
- WIDTH, 16: LFSR and data width; valid range 4..32.
- TAPS, 16'hB400: Galois feedback mask, XORed in when the shifted-out bit is 1. The default is maximal length, period 65535.
- SEED, 16'h000F: state after reset; must be nonzero.
- MAX_DRAWS, 8: rejection attempts before fallback; valid range ≥1.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  advance LFSR one step per cycle while FSM idle.
- seed_load  in  1  load seed_in into LFSR this cycle.
- seed_in  in  WIDTH  seed value.
- req  in  1  request one bounded draw; sampled only in IDLE.
- limit  in  WIDTH  inclusive upper bound; latched when req is accepted.
- busy  out  1  high from accepted req until rand_valid.
- rand_out  out  WIDTH  result, held until next result.
- rand_valid  out  1  one-cycle pulse, rand_out valid.
- raw_out  out  WIDTH  current LFSR state.
- lockup  out  1  one-cycle pulse when a zero state is repaired (see Configuration).

## Operation
- Step function: next = (s >> 1) ^ (s[0] ? TAPS : 0).
- Priority per edge:
  - reset is highest priority.
  - seed_load is next.
  - A step follows. The LFSR steps when in DRAW, or when in IDLE with en=1.
- seed_load replaces that cycle's step. In DRAW, no draw is evaluated and the draw count is not incremented that cycle.
- Mask = smallest all-ones value ≥ limit_q, formed by an OR-smear of limit_q. Candidate = s & mask.
- FSM has two states, IDLE and DRAW.
  - IDLE, req=1: latch limit_q ← limit, set draw count to 0, busy ← 1, go to DRAW. The LFSR steps on this edge only if en=1.
  - DRAW, each edge: evaluate the candidate from the pre-edge state, step the LFSR, increment the draw count.
    - If candidate ≤ limit_q: rand_out ← candidate, rand_valid ← 1, busy ← 0, go to IDLE.
    - Else, if this was draw number MAX_DRAWS: rand_out ← candidate − (limit_q+1), which is always in range because mask < 2·(limit_q+1); assert rand_valid, go to IDLE.
    - Else stay in DRAW.
- A req while busy is ignored and not queued. A limit change after acceptance has no effect.
- limit=0 returns 0 on the first draw. limit = all-ones returns raw state bits on the first draw.
- en is ignored in DRAW.

## Timing
- Reset values:
  - LFSR = SEED, so raw_out = SEED.
  - rand_out = 0, rand_valid = 0, busy = 0, lockup = 0.
  - FSM = IDLE.
- Latency: req sampled at edge E0. With k rejections (k < MAX_DRAWS), rand_valid is high for the cycle after edge E(k+1). Worst case is the cycle after E(MAX_DRAWS).
- A new req may be sampled on the edge at which rand_valid is high (FSM already IDLE). Throughput is one draw per 2 cycles at best.
- Reset mid-DRAW: the next cycle is idle with busy=0 and rand_valid=0. No result is produced.
- raw_out reflects a step or load one edge after it is requested.

## Configuration
- LFSR_LOCKUP_GUARD_EN defined:
  - Any edge that would leave the LFSR all-zero loads SEED instead and pulses lockup for one cycle.
  - This applies to seed_load of 0 and to a zero step. A zero step is reachable only through a non-maximal TAPS.
- Undefined:
  - All-zero is stored as-is and the LFSR stays zero.
  - Every draw returns 0 on the first draw.
  - lockup is tied 0.

## Test plan
- Reset, then en=1 for one cycle (defaults) -> raw_out 0x000F then 0xB407. rand_out=0, busy=0.
- Reset, en=0, req with limit=0xFFFF -> accepted on draw 1; rand_out=0x000F, rand_valid pulse after E1; busy high for exactly 1 cycle.
- Reset, en=0, req with limit=9 -> draw 1 rejects 15; draw 2 accepts 7 (state 0xB407); rand_out=7 after E2. A second req during busy is ignored (exactly one rand_valid).
- MAX_DRAWS=1, reset, en=0, req with limit=9 -> fallback 15−10; rand_out=5 after E1.
- seed_load=1, seed_in=0:
  - With LFSR_LOCKUP_GUARD_EN: raw_out=0x000F, lockup pulse.
  - Without: raw_out stays 0 under en=1; req with limit=9 -> rand_out=0 after E1.
- req with limit=9 from seed 0x000F, reset asserted on edge E1 -> busy=0, rand_valid never pulses, raw_out=0x000F, next req behaves as after fresh reset.
